// File: rtl/reg_block_queue.sv
// Bus-mapped staging registers that assemble a block and queue it in a small FIFO
// feeding the hash core, with CTRL (push/flush/clear-error) and STATUS registers.
module reg_block_queue #(
    parameter int DataWidth  = 64,
    parameter int AddrWidth  = 32,
    parameter int BlockWidth = 512,
    parameter int Depth      = 4,
    parameter int ByteAlign  = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [DataWidth-1:0]    reqdata_i,
    input  logic [AddrWidth-1:0]    reqaddr_i,
    input  logic                    reqvalid_i,
    input  logic                    reqwrite_i,
    input  logic [DataWidth/8-1:0]  reqstrobe_i,
    output logic                    reqready_o,
    input  logic                    rspready_i,
    output logic                    rspvalid_o,
    output logic [DataWidth-1:0]    rspdata_o,
    output logic                    rsperror_o,
    input  logic                    idle_i,
    output logic [BlockWidth-1:0]   block_o,
    output logic                    block_valid_o,
    input  logic                    block_ready_i,
    output logic                    reset_hash_o
);

    localparam int NumRegs  = BlockWidth / DataWidth;
    localparam int StrbW    = DataWidth / 8;
    localparam int AddrStep = (ByteAlign != 0) ? DataWidth / 8 : DataWidth / 32;
    localparam int AddrBits = $clog2(NumRegs * AddrStep);
    localparam int CntW     = $clog2(Depth + 1);
    localparam int PtrW     = (Depth > 1) ? $clog2(Depth) : 1;

    localparam logic [AddrBits:0] CtrlOff   = {1'b1, {AddrBits{1'b0}}};
    localparam logic [AddrBits:0] StatusOff = CtrlOff + (AddrBits + 1)'(AddrStep);

    logic [BlockWidth-1:0] stage_q, stage_d;
    logic [BlockWidth-1:0] mem_q [Depth];
    logic [CntW-1:0]       count_q, count_d;
    logic [PtrW-1:0]       head_q, head_d;
    logic [PtrW-1:0]       tail_q, tail_d;
    logic                  overflow_q, overflow_d;
    logic                  resetHash_q, resetHash_d;

    logic [AddrBits:0]     offset;
    int                    offInt;
    int                    wordIdx;
    logic                  isStage, isCtrl, isStatus;
    logic                  accept, wrAccept, ctrlAct;
    logic                  pushReq, flushReq, clrReq;
    logic                  pushEn, popEn, rejectPush;
    logic                  full, empty;
    logic                  addrErr, statusWrErr;
    logic [DataWidth-1:0]  statusWord;
    logic                  unusedAddrBits;

    function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign unusedAddrBits = ^reqaddr_i[AddrWidth-1:AddrBits+1];

    // Address decode; bits above the register window alias back into it.
    always_comb begin
        offset   = reqaddr_i[AddrBits:0];
        offInt   = int'(offset[AddrBits-1:0]);
        wordIdx  = offInt / AddrStep;
        isStage  = !offset[AddrBits] && ((offInt % AddrStep) == 0) && (wordIdx < NumRegs);
        isCtrl   = (offset == CtrlOff);
        isStatus = (offset == StatusOff);
    end

    assign reqready_o    = rst_ni;
    assign accept        = reqvalid_i & reqready_o;
    assign wrAccept      = accept & reqwrite_i;
    assign ctrlAct       = wrAccept & isCtrl & reqstrobe_i[0];
    assign pushReq       = ctrlAct & reqdata_i[0];
    assign flushReq      = ctrlAct & reqdata_i[1];
    assign clrReq        = ctrlAct & reqdata_i[2];

    assign full          = (count_q == CntW'(Depth));
    assign empty         = (count_q == '0);
    assign block_valid_o = !empty;
    assign block_o       = mem_q[head_q];
    assign reset_hash_o  = resetHash_q;

    // Flush wins over everything; a push into a full queue is refused and flagged.
    assign popEn         = block_valid_o & block_ready_i & !flushReq;
    assign pushEn        = pushReq & !full & !flushReq;
    assign rejectPush    = pushReq & full & !flushReq;

    assign addrErr       = accept & !(isStage | isCtrl | isStatus);
    assign statusWrErr   = wrAccept & isStatus;
    assign rsperror_o    = addrErr | statusWrErr | rejectPush;
    assign rspvalid_o    = reqvalid_i & rspready_i;

    always_comb begin
        statusWord         = '0;
        statusWord[CntW-1:0] = count_q;
        statusWord[8]      = empty;
        statusWord[9]      = full;
        statusWord[10]     = overflow_q;
        statusWord[11]     = idle_i;
    end

    // Read data reflects register contents before the current edge.
    always_comb begin
        rspdata_o = '0;
        if (isStage) begin
            rspdata_o = stage_q[wordIdx*DataWidth +: DataWidth];
        end else if (isStatus) begin
            rspdata_o = statusWord;
        end
    end

    always_comb begin
        stage_d = stage_q;
        if (wrAccept && isStage) begin
            for (int b = 0; b < StrbW; b++) begin
                if (reqstrobe_i[b]) begin
                    stage_d[wordIdx*DataWidth + b*8 +: 8] = reqdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Queue bookkeeping: pointers wrap modulo Depth, count tracks push/pop.
    always_comb begin
        count_d     = count_q;
        head_d      = head_q;
        tail_d      = tail_q;
        overflow_d  = overflow_q;
        resetHash_d = flushReq;
        if (flushReq) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (pushEn) begin
                tail_d = nextPtr(tail_q);
            end
            if (popEn) begin
                head_d = nextPtr(head_q);
            end
            case ({pushEn, popEn})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
        if (rejectPush) begin
            overflow_d = 1'b1;
        end else if (clrReq) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q     <= '0;
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            overflow_q  <= 1'b0;
            resetHash_q <= 1'b0;
        end else begin
            stage_q     <= stage_d;
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            overflow_q  <= overflow_d;
            resetHash_q <= resetHash_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < Depth; e++) begin
                mem_q[e] <= '0;
            end
        end else if (pushEn) begin
            mem_q[tail_q] <= stage_q;
        end
    end

endmodule

// File: tb/tb_reg_block_queue.sv
// Directed self-checking bench for reg_block_queue with default parameters
// (CTRL at 0x40, STATUS at 0x48, Depth 4).
module tb_reg_block_queue;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [63:0]  reqdata_i;
    logic [31:0]  reqaddr_i;
    logic         reqvalid_i;
    logic         reqwrite_i;
    logic [7:0]   reqstrobe_i;
    logic         reqready_o;
    logic         rspready_i;
    logic         rspvalid_o;
    logic [63:0]  rspdata_o;
    logic         rsperror_o;
    logic         idle_i;
    logic [511:0] block_o;
    logic         block_valid_o;
    logic         block_ready_i;
    logic         reset_hash_o;

    int           testsRun  = 0;
    int           failCount = 0;
    logic [63:0]  rdData;
    logic         rdErr;
    logic         rdVld;

    reg_block_queue dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .reqdata_i     (reqdata_i),
        .reqaddr_i     (reqaddr_i),
        .reqvalid_i    (reqvalid_i),
        .reqwrite_i    (reqwrite_i),
        .reqstrobe_i   (reqstrobe_i),
        .reqready_o    (reqready_o),
        .rspready_i    (rspready_i),
        .rspvalid_o    (rspvalid_o),
        .rspdata_o     (rspdata_o),
        .rsperror_o    (rsperror_o),
        .idle_i        (idle_i),
        .block_o       (block_o),
        .block_valid_o (block_valid_o),
        .block_ready_i (block_ready_i),
        .reset_hash_o  (reset_hash_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One bus transaction; response sampled mid-cycle, optional pop in the same cycle.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [63:0] data,
                                 input logic [7:0] strb, input logic pop);
        @(negedge clk_i);
        reqvalid_i    = 1'b1;
        reqwrite_i    = wr;
        reqaddr_i     = addr;
        reqdata_i     = data;
        reqstrobe_i   = strb;
        block_ready_i = pop;
        #1;
        rdData = rspdata_o;
        rdErr  = rsperror_o;
        rdVld  = rspvalid_o;
        @(posedge clk_i);
        #1;
        reqvalid_i    = 1'b0;
        reqwrite_i    = 1'b0;
        block_ready_i = 1'b0;
    endtask

    task automatic popOnce();
        @(negedge clk_i);
        block_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        block_ready_i = 1'b0;
    endtask

    task automatic readStatus(input string tag, input logic [63:0] expected);
        applyStimulus(1'b0, 32'h48, 64'h0, 8'h00, 1'b0);
        checkOutput(tag, rdData, expected);
    endtask

    initial begin
        rst_ni        = 1'b0;
        reqdata_i     = '0;
        reqaddr_i     = 32'h50;
        reqvalid_i    = 1'b1;
        reqwrite_i    = 1'b0;
        reqstrobe_i   = '0;
        rspready_i    = 1'b1;
        idle_i        = 1'b0;
        block_ready_i = 1'b0;

        #12;
        checkOutput("rst_block_valid", block_valid_o, 1'b0);
        checkOutput("rst_reset_hash", reset_hash_o, 1'b0);
        checkOutput("rst_reqready", reqready_o, 1'b0);
        checkOutput("rst_rsperror", rsperror_o, 1'b0);
        reqvalid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        checkOutput("reqready_after_rst", reqready_o, 1'b1);
        readStatus("status_after_rst", 64'h100);
        checkOutput("status_rspvalid", rdVld, 1'b1);

        for (int r = 0; r < 8; r++) begin
            applyStimulus(1'b1, 32'(r * 8), 64'(r + 1) * 64'h0101, 8'hFF, 1'b0);
            checkOutput("stage_write_err", rdErr, 1'b0);
        end
        applyStimulus(1'b0, 32'h08, 64'h0, 8'h00, 1'b0);
        checkOutput("stage_read_1", rdData, 64'h0202);

        applyStimulus(1'b1, 32'h40, 64'h1, 8'hFF, 1'b0);
        checkOutput("push1_err", rdErr, 1'b0);
        checkOutput("push1_block_valid", block_valid_o, 1'b1);
        checkOutput("push1_block_w0", block_o[63:0], 64'h0101);
        checkOutput("push1_block_w7", block_o[511:448], 64'h0808);
        idle_i = 1'b1;
        readStatus("status_count1_idle", 64'h801);
        idle_i = 1'b0;

        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, 32'h0, 64'hA0 + 64'(k), 8'hFF, 1'b0);
            applyStimulus(1'b1, 32'h40, 64'h1, 8'hFF, 1'b0);
            checkOutput("fill_push_err", rdErr, 1'b0);
        end
        readStatus("status_full", 64'h204);
        applyStimulus(1'b1, 32'h40, 64'h1, 8'hFF, 1'b0);
        checkOutput("overflow_push_err", rdErr, 1'b1);
        readStatus("status_overflow", 64'h604);
        checkOutput("overflow_head_kept", block_o[63:0], 64'h0101);

        applyStimulus(1'b1, 32'h48, 64'h0, 8'hFF, 1'b0);
        checkOutput("status_write_err", rdErr, 1'b1);
        readStatus("status_after_wr", 64'h604);
        applyStimulus(1'b0, 32'h50, 64'h0, 8'h00, 1'b0);
        checkOutput("unmapped_err", rdErr, 1'b1);
        checkOutput("unmapped_data", rdData, 64'h0);
        applyStimulus(1'b0, 32'h04, 64'h0, 8'h00, 1'b0);
        checkOutput("misaligned_err", rdErr, 1'b1);
        applyStimulus(1'b0, 32'h88, 64'h0, 8'h00, 1'b0);
        checkOutput("alias_data", rdData, 64'h0202);
        checkOutput("alias_err", rdErr, 1'b0);
        applyStimulus(1'b0, 32'h40, 64'h0, 8'h00, 1'b0);
        checkOutput("ctrl_read_zero", rdData, 64'h0);
        rspready_i = 1'b0;
        applyStimulus(1'b0, 32'h48, 64'h0, 8'h00, 1'b0);
        checkOutput("rspvalid_gated", rdVld, 1'b0);
        rspready_i = 1'b1;

        applyStimulus(1'b1, 32'h40, 64'h5, 8'hFF, 1'b0);
        checkOutput("clr_with_reject_err", rdErr, 1'b1);
        readStatus("status_clr_reject", 64'h604);
        applyStimulus(1'b1, 32'h40, 64'h4, 8'hFF, 1'b0);
        checkOutput("clr_err", rdErr, 1'b0);
        applyStimulus(1'b1, 32'h40, 64'h1, 8'hFE, 1'b0);
        checkOutput("ctrl_nostrobe_err", rdErr, 1'b0);
        readStatus("status_cleared", 64'h204);

        popOnce();
        popOnce();
        checkOutput("pop2_head", block_o[63:0], 64'hA2);
        readStatus("status_count2", 64'h002);
        applyStimulus(1'b1, 32'h0, 64'hB4, 8'hFF, 1'b0);
        applyStimulus(1'b1, 32'h40, 64'h1, 8'hFF, 1'b1);
        checkOutput("pushpop_err", rdErr, 1'b0);
        checkOutput("pushpop_head", block_o[63:0], 64'hA3);
        readStatus("status_pushpop", 64'h002);
        popOnce();
        checkOutput("wrap_head", block_o[63:0], 64'hB4);
        readStatus("status_count1", 64'h001);

        applyStimulus(1'b1, 32'h0, 64'h0, 8'hFF, 1'b0);
        applyStimulus(1'b1, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0, 8'h00, 1'b0);
        checkOutput("strobe_partial", rdData, 64'h0000_0000_FFFF_FFFF);

        applyStimulus(1'b1, 32'h40, 64'h1, 8'hFF, 1'b0);
        applyStimulus(1'b1, 32'h40, 64'h1, 8'hFF, 1'b0);
        readStatus("status_count3", 64'h003);
        applyStimulus(1'b1, 32'h40, 64'h3, 8'hFF, 1'b0);
        checkOutput("flush_err", rdErr, 1'b0);
        checkOutput("flush_block_valid", block_valid_o, 1'b0);
        checkOutput("flush_reset_hash", reset_hash_o, 1'b1);
        @(posedge clk_i);
        #1;
        checkOutput("flush_reset_hash_end", reset_hash_o, 1'b0);
        readStatus("status_after_flush", 64'h100);

        applyStimulus(1'b1, 32'h40, 64'h1, 8'hFF, 1'b0);
        checkOutput("empty_push_valid", block_valid_o, 1'b1);
        checkOutput("empty_push_w0", block_o[63:0], 64'hFFFF_FFFF);
        applyStimulus(1'b1, 32'h40, 64'h1, 8'hFF, 1'b0);
        applyStimulus(1'b1, 32'h40, 64'h1, 8'hFF, 1'b0);
        readStatus("status_pre_reset", 64'h003);

        @(negedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        checkOutput("async_rst_valid", block_valid_o, 1'b0);
        checkOutput("async_rst_ready", reqready_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        readStatus("status_post_reset", 64'h100);
        applyStimulus(1'b0, 32'h38, 64'h0, 8'h00, 1'b0);
        checkOutput("stage_cleared", rdData, 64'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/reg_block_queue.md
REG_BLOCK_QUEUE -- requirements
Module: reg_block_queue

Interface
REQ-001 SHALL have parameter DataWidth, default 64: bus data width in bits, multiple of 8.
REQ-002 SHALL have parameter AddrWidth, default 32: bus address width in bits.
REQ-003 SHALL have parameter BlockWidth, default 512: block width, an integer multiple of DataWidth.
REQ-004 SHALL have parameter Depth, default 4: FIFO depth in blocks, at least 2.
REQ-005 SHALL have parameter ByteAlign, default 1: 1 selects byte addressing, 0 selects 32-bit-word addressing.
REQ-006 SHALL have port clk_i, input, 1 bit: clock, rising edge.
REQ-007 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have ports reqdata_i (input, DataWidth), reqaddr_i (input, AddrWidth), reqvalid_i (input, 1), reqwrite_i (input, 1) and reqstrobe_i (input, DataWidth/8): bus request.
REQ-009 SHALL have port reqready_o, output, 1 bit: request accepted.
REQ-010 SHALL have ports rspready_i (input, 1), rspvalid_o (output, 1), rspdata_o (output, DataWidth) and rsperror_o (output, 1): bus response.
REQ-011 SHALL have port idle_i, input, 1 bit: hash core idle.
REQ-012 SHALL have ports block_o (output, BlockWidth), block_valid_o (output, 1) and block_ready_i (input, 1): block stream to the hash core.
REQ-013 SHALL have port reset_hash_o, output, 1 bit: one-cycle hash-core reset pulse.

Function
REQ-014 SHALL derive NumRegs = BlockWidth/DataWidth, AddrStep = DataWidth/(8 if ByteAlign else 32), AddrBits = clog2(NumRegs*AddrStep) and CntW = clog2(Depth+1).
REQ-015 SHALL map staging word r at address r*AddrStep, CTRL at 1<<AddrBits and STATUS at (1<<AddrBits)+AddrStep; bits of reqaddr_i above AddrBits are ignored.
REQ-016 SHALL, for a staging-word write, update each byte b where reqstrobe_i[b]=1 at the next clock edge.
REQ-017 SHALL hold reqready_o at 1 out of reset.
REQ-018 SHALL drive rspvalid_o = reqvalid_i & rspready_i combinationally for every address, mapped or unmapped.
REQ-019 SHALL drive rspdata_o combinationally from pre-edge register values: the staging word, CTRL reads as 0, or STATUS.
REQ-020 SHALL lay out STATUS as count in [CntW-1:0], empty in [8], full in [9], overflow in [10], idle_i in [11], with all other bits 0.
REQ-021 SHALL act on CTRL writes only when reqstrobe_i[0]=1: bit0 PUSH, bit1 FLUSH, bit2 CLR_ERR.
REQ-022 SHALL, on PUSH with registered count < Depth, copy all staging words (word r to block bits [r*DataWidth +: DataWidth]) into the tail entry at the next edge and increment count; the staging registers are not cleared.
REQ-023 SHALL, on PUSH with registered count = Depth, leave the FIFO unchanged, set sticky overflow and assert rsperror_o in that cycle, even if a pop occurs in the same cycle.
REQ-024 SHALL drive block_o = head entry and block_valid_o = (count != 0); a pop occurs when block_valid_o & block_ready_i.
REQ-025 SHALL update count by PUSH +1 and pop -1 when both occur in one cycle with count < Depth, giving net 0, with head and tail pointers wrapping modulo Depth.
REQ-026 SHALL, on FLUSH, set count, head and tail to 0 at the next edge and assert reset_hash_o for exactly the following cycle.
REQ-027 SHALL give FLUSH priority over a simultaneous PUSH and pop; both are discarded and no overflow is raised.
REQ-028 SHALL clear overflow on CLR_ERR unless a rejected PUSH occurs in the same write, in which case overflow stays set.
REQ-029 SHALL raise rsperror_o with no state change for writes to STATUS and for accesses to unmapped addresses inside the (1<<(AddrBits+1)) window.
REQ-030 SHALL assert block_valid_o one cycle after an accepted PUSH into an empty FIFO.

Reset
REQ-031 SHALL, while rst_ni=0, asynchronously clear staging registers, FIFO entries, count, pointers and overflow, and hold block_valid_o=0, reset_hash_o=0, rsperror_o=0 and reqready_o=0; reset mid-operation discards all queued blocks.

Verification (defaults: CTRL=0x40, STATUS=0x48)
REQ-032 SHALL cover: write 0x0..0x38 with 0x0101..0x0808 (full strobe), then PUSH -> next cycle block_valid_o=1, block_o[63:0]=0x0101, STATUS.count=1.
REQ-033 SHALL cover: with block_ready_i=0, four PUSHes then a fifth -> fifth has rsperror_o=1 and STATUS reads 0x604 (full, overflow, count 4).
REQ-034 SHALL cover: write 0x0 with data 0xFFFF_FFFF_FFFF_FFFF and strobe 0x0F over 0 -> read 0x0 returns 0x0000_0000_FFFF_FFFF.
REQ-035 SHALL cover: count=2 with PUSH and block_ready_i=1 in the same cycle -> count stays 2 and head advances by one.
REQ-036 SHALL cover: count=3, write CTRL=0x3 (PUSH+FLUSH) -> count=0, reset_hash_o high for one cycle, overflow=0.
REQ-037 SHALL cover: rst_ni deasserted asynchronously with count=3 -> block_valid_o=0 immediately; after release STATUS=0x100 with idle_i=0.
